// File: rtl/writeback_unit_if.sv
// Bus between the MEM/WB pipeline buffer / register-file consumers and the writeback unit.
// master drives the pipeline results and read addresses; slave is the writeback unit.
interface writeback_unit_if #(
    parameter int S = 15,
    parameter int A = 3
);
    logic [S:0]  InWord;
    logic [7:0]  InByte;
    logic [S:0]  InCtrl;
    logic [A:0]  RdAddrA;
    logic [A:0]  RdAddrB;
    logic [S:0]  OutRdA;
    logic [S:0]  OutRdB;
    logic        OutFwdValid;
    logic [A:0]  OutFwdDest;
    logic [S:0]  OutFwdData;
    logic        OutHalted;
    logic [15:0] OutRetired;
    logic        DbgState;

    modport master (
        output InWord, InByte, InCtrl, RdAddrA, RdAddrB,
        input  OutRdA, OutRdB, OutFwdValid, OutFwdDest, OutFwdData,
        input  OutHalted, OutRetired, DbgState
    );

    modport slave (
        input  InWord, InByte, InCtrl, RdAddrA, RdAddrB,
        output OutRdA, OutRdB, OutFwdValid, OutFwdDest, OutFwdData,
        output OutHalted, OutRetired, DbgState
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: register file with write-through read ports, forwarding registers,
// retired-write counter and a RUN/HALTED FSM.
// No valid/ready handshake: every cycle the buffer presents one control word; all-zero is a bubble.
module writeback_unit #(
    parameter int S = 15,
    parameter int A = 3
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  bus
);
    localparam int NREG = 2 ** (A + 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [S:0]  rf_q [NREG];
    logic [15:0] retired_q, retired_d;
    logic        fwd_valid_q, fwd_valid_d;
    logic [A:0]  fwd_dest_q, fwd_dest_d;
    logic [S:0]  fwd_data_q, fwd_data_d;

    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        halt_req;
    logic [A:0]  dest;
    logic [S:0]  wdata;
    logic        run_active;
    logic        halted;
    logic        commit;
    logic        unused_ctrl;

    assign reg_write   = bus.InCtrl[15];
    assign wb_sel      = bus.InCtrl[14:13];
    assign halt_req    = bus.InCtrl[12];
    assign dest        = bus.InCtrl[A+8:8];
    assign unused_ctrl = ^bus.InCtrl[7:0];

    // Byte insert keeps the stored low byte and replaces bits 15:8.
    always_comb begin
        wdata = '0;
        case (wb_sel)
            2'b00: wdata = bus.InWord;
            2'b01: wdata = {{(S-7){1'b0}}, bus.InByte};
            2'b10: wdata = {{(S-7){bus.InByte[7]}}, bus.InByte};
            default: wdata[15:0] = {bus.InByte, rf_q[dest][7:0]};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_req) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_active = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RUN:    run_active = 1'b1;
            ST_HALTED: halted     = 1'b1;
            default:   run_active = 1'b0;
        endcase
    end

    assign commit = run_active && reg_write && (dest != '0);

    always_comb begin
        retired_d   = retired_q;
        fwd_valid_d = commit;
        fwd_dest_d  = fwd_dest_q;
        fwd_data_d  = fwd_data_q;
        if (commit) begin
            fwd_dest_d = dest;
            fwd_data_d = wdata;
            if (retired_q != 16'hFFFF) begin
                retired_d = retired_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            retired_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_dest_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            if (commit) begin
                rf_q[dest] <= wdata;
            end
            retired_q   <= retired_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_dest_q  <= fwd_dest_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // commit is never true in HALTED, so the bypass switches off there automatically.
    always_comb begin
        if (bus.RdAddrA == '0) begin
            bus.OutRdA = '0;
        end else if (commit && (bus.RdAddrA == dest)) begin
            bus.OutRdA = wdata;
        end else begin
            bus.OutRdA = rf_q[bus.RdAddrA];
        end
    end

    always_comb begin
        if (bus.RdAddrB == '0) begin
            bus.OutRdB = '0;
        end else if (commit && (bus.RdAddrB == dest)) begin
            bus.OutRdB = wdata;
        end else begin
            bus.OutRdB = rf_q[bus.RdAddrB];
        end
    end

    assign bus.OutFwdValid = fwd_valid_q;
    assign bus.OutFwdDest  = fwd_dest_q;
    assign bus.OutFwdData  = fwd_data_q;
    assign bus.OutHalted   = halted;
    assign bus.OutRetired  = retired_q;
    assign bus.DbgState    = state_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a random back-to-back run.
module tb_writeback_unit;
  localparam int S = 15;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ref_rf[16];
  logic [15:0] exp_ret;

  writeback_unit_if #(.S(S), .A(A)) bus();
  writeback_unit #(.S(S), .A(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ctrl, input logic [15:0] word, input logic [7:0] byt);
    bus.InCtrl = ctrl;
    bus.InWord = word;
    bus.InByte = byt;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(16'h0000, 16'h0000, 8'h00);
    step();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
    exp_ret = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.OutFwdValid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid: got %b expected 0", bus.OutFwdValid); end
    checks++; if (bus.OutFwdDest !== 4'h0) begin failures++; $display("FAIL reset_fwd_dest: got %h expected 0", bus.OutFwdDest); end
    checks++; if (bus.OutFwdData !== 16'h0000) begin failures++; $display("FAIL reset_fwd_data: got %h expected 0000", bus.OutFwdData); end
    checks++; if (bus.OutRetired !== 16'h0000) begin failures++; $display("FAIL reset_retired: got %h expected 0000", bus.OutRetired); end
    checks++; if (bus.OutHalted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", bus.OutHalted); end
    for (int i = 1; i < 16; i++) begin
      bus.RdAddrA = 4'(i);
      #1;
      checks++; if (bus.OutRdA !== 16'h0000) begin failures++; $display("FAIL reset_rf[%0d]: got %h expected 0000", i, bus.OutRdA); end
    end
  endtask

  task automatic test_word_write();
    logic [15:0] e;
    drive(16'h8300, 16'hBEEF, 8'h00);
    exp_q.push_back(16'hBEEF);
    step();
    drive(16'h0000, 16'h0000, 8'h00);
    bus.RdAddrA = 4'd3;
    #1;
    checks++; if (bus.OutFwdValid !== 1'b1) begin failures++; $display("FAIL word_fwd_valid: got %b expected 1", bus.OutFwdValid); end
    checks++; if (bus.OutFwdDest !== 4'd3) begin failures++; $display("FAIL word_fwd_dest: got %h expected 3", bus.OutFwdDest); end
    e = exp_q.pop_front();
    checks++; if (bus.OutFwdData !== e) begin failures++; $display("FAIL word_fwd_data: got %h expected %h", bus.OutFwdData, e); end
    checks++; if (bus.OutRetired !== 16'd1) begin failures++; $display("FAIL word_retired: got %h expected 0001", bus.OutRetired); end
    checks++; if (bus.OutRdA !== 16'hBEEF) begin failures++; $display("FAIL word_rf3: got %h expected beef", bus.OutRdA); end
    step();
    checks++; if (bus.OutFwdValid !== 1'b0) begin failures++; $display("FAIL word_fwd_valid_drop: got %b expected 0", bus.OutFwdValid); end
    checks++; if (bus.OutFwdData !== 16'hBEEF) begin failures++; $display("FAIL word_fwd_data_hold: got %h expected beef", bus.OutFwdData); end
    checks++; if (bus.OutFwdDest !== 4'd3) begin failures++; $display("FAIL word_fwd_dest_hold: got %h expected 3", bus.OutFwdDest); end
    exp_ret = 16'd1;
  endtask

  task automatic test_byte_modes();
    logic [15:0] ctrl_tab [4] = '{16'hA500, 16'hC500, 16'h8500, 16'hE500};
    logic [15:0] word_tab [4] = '{16'h0000, 16'h0000, 16'h1234, 16'h0000};
    logic [15:0] res_tab  [4] = '{16'h009A, 16'hFF9A, 16'h1234, 16'h9A34};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(ctrl_tab[i], word_tab[i], 8'h9A);
      exp_q.push_back(res_tab[i]);
      step();
      exp_ret = exp_ret + 16'd1;
      drive(16'h0000, 16'h0000, 8'h00);
      bus.RdAddrB = 4'd5;
      #1;
      e = exp_q.pop_front();
      checks++; if (bus.OutFwdData !== e) begin failures++; $display("FAIL byte_mode%0d_fwd: got %h expected %h", i, bus.OutFwdData, e); end
      checks++; if (bus.OutRdB !== e) begin failures++; $display("FAIL byte_mode%0d_rf5: got %h expected %h", i, bus.OutRdB, e); end
    end
    checks++; if (bus.OutRetired !== exp_ret) begin failures++; $display("FAIL byte_retired: got %h expected %h", bus.OutRetired, exp_ret); end
  endtask

  task automatic test_bypass();
    drive(16'h8700, 16'h5555, 8'h00);
    bus.RdAddrA = 4'd7;
    bus.RdAddrB = 4'd0;
    #1;
    checks++; if (bus.OutRdA !== 16'h5555) begin failures++; $display("FAIL bypass_rda: got %h expected 5555", bus.OutRdA); end
    checks++; if (bus.OutRdB !== 16'h0000) begin failures++; $display("FAIL bypass_rdb_r0: got %h expected 0000", bus.OutRdB); end
    step();
    exp_ret = exp_ret + 16'd1;
    drive(16'h8000, 16'hFFFF, 8'hFF);
    step();
    drive(16'h0000, 16'h0000, 8'h00);
    #1;
    checks++; if (bus.OutFwdValid !== 1'b0) begin failures++; $display("FAIL r0_fwd_valid: got %b expected 0", bus.OutFwdValid); end
    checks++; if (bus.OutRetired !== exp_ret) begin failures++; $display("FAIL r0_retired: got %h expected %h", bus.OutRetired, exp_ret); end
    checks++; if (bus.OutRdB !== 16'h0000) begin failures++; $display("FAIL r0_read: got %h expected 0000", bus.OutRdB); end
    checks++; if (bus.OutRdA !== 16'h5555) begin failures++; $display("FAIL bypass_r7_stored: got %h expected 5555", bus.OutRdA); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(16'h9200, 16'h0001, 8'h00);
    step();
    drive(16'h0000, 16'h0000, 8'h00);
    bus.RdAddrA = 4'd2;
    #1;
    checks++; if (bus.OutRdA !== 16'h0001) begin failures++; $display("FAIL halt_r2: got %h expected 0001", bus.OutRdA); end
    checks++; if (bus.OutHalted !== 1'b1) begin failures++; $display("FAIL halt_halted: got %b expected 1", bus.OutHalted); end
    checks++; if (bus.OutRetired !== 16'd1) begin failures++; $display("FAIL halt_retired: got %h expected 0001", bus.OutRetired); end
    drive(16'h8400, 16'h7777, 8'h00);
    bus.RdAddrA = 4'd4;
    #1;
    checks++; if (bus.OutRdA !== 16'h0000) begin failures++; $display("FAIL halt_no_bypass: got %h expected 0000", bus.OutRdA); end
    step();
    drive(16'h0000, 16'h0000, 8'h00);
    #1;
    checks++; if (bus.OutRdA !== 16'h0000) begin failures++; $display("FAIL halt_r4_frozen: got %h expected 0000", bus.OutRdA); end
    checks++; if (bus.OutRetired !== 16'd1) begin failures++; $display("FAIL halt_retired_frozen: got %h expected 0001", bus.OutRetired); end
    checks++; if (bus.OutFwdValid !== 1'b0) begin failures++; $display("FAIL halt_fwd_valid: got %b expected 0", bus.OutFwdValid); end
    checks++; if (bus.OutHalted !== 1'b1) begin failures++; $display("FAIL halt_sticky: got %b expected 1", bus.OutHalted); end
    do_reset();
    bus.RdAddrA = 4'd2;
    #1;
    checks++; if (bus.OutHalted !== 1'b0) begin failures++; $display("FAIL halt_reset_halted: got %b expected 0", bus.OutHalted); end
    checks++; if (bus.OutRdA !== 16'h0000) begin failures++; $display("FAIL halt_reset_r2: got %h expected 0000", bus.OutRdA); end
    checks++; if (bus.OutRetired !== 16'h0000) begin failures++; $display("FAIL halt_reset_retired: got %h expected 0000", bus.OutRetired); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16'hFFFE; i++) begin
      drive(16'h8100, 16'(i), 8'h00);
      step();
    end
    drive(16'h0000, 16'h0000, 8'h00);
    #1;
    checks++; if (bus.OutRetired !== 16'hFFFE) begin failures++; $display("FAIL sat_preload: got %h expected fffe", bus.OutRetired); end
    for (int i = 0; i < 3; i++) begin
      drive(16'h8100, 16'h00AA, 8'h00);
      step();
    end
    drive(16'h0000, 16'h0000, 8'h00);
    #1;
    checks++; if (bus.OutRetired !== 16'hFFFF) begin failures++; $display("FAIL sat_final: got %h expected ffff", bus.OutRetired); end
  endtask

  task automatic test_reset_collision();
    drive(16'h8600, 16'h1111, 8'h00);
    step();
    rst = 1'b0;
    drive(16'h9600, 16'h2222, 8'h00);
    step();
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 8'h00);
    bus.RdAddrA = 4'd6;
    #1;
    checks++; if (bus.OutRdA !== 16'h0000) begin failures++; $display("FAIL coll_r6: got %h expected 0000", bus.OutRdA); end
    checks++; if (bus.OutFwdValid !== 1'b0) begin failures++; $display("FAIL coll_fwd_valid: got %b expected 0", bus.OutFwdValid); end
    checks++; if (bus.OutRetired !== 16'h0000) begin failures++; $display("FAIL coll_retired: got %h expected 0000", bus.OutRetired); end
    checks++; if (bus.OutHalted !== 1'b0) begin failures++; $display("FAIL coll_halted: got %b expected 0", bus.OutHalted); end
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
    exp_ret = 16'h0000;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ctrl, word, wd, e;
    logic [7:0] byt;
    logic [3:0] d, ra;
    logic cm;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      d = 4'($urandom_range(0, 15));
      ctrl = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, d, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) == 0) ctrl = 16'h0000;
      word = 16'($urandom);
      byt = 8'($urandom);
      case (ctrl[14:13])
        2'b00: wd = word;
        2'b01: wd = {8'h00, byt};
        2'b10: wd = {{8{byt[7]}}, byt};
        default: wd = {byt, ref_rf[d][7:0]};
      endcase
      cm = ctrl[15] && (d != 4'd0);
      drive(ctrl, word, byt);
      ra = 4'($urandom_range(0, 15));
      bus.RdAddrA = ra;
      #1;
      e = (ra == 4'd0) ? 16'h0000 : ((cm && ra == d) ? wd : ref_rf[ra]);
      checks++; if (bus.OutRdA !== e) begin failures++; $display("FAIL b2b_read[%0d]: got %h expected %h", n, bus.OutRdA, e); end
      if (cm) begin
        exp_q.push_back(wd);
        ref_rf[d] = wd;
        exp_ret = exp_ret + 16'd1;
      end
      step();
      checks++; if (bus.OutFwdValid !== cm) begin failures++; $display("FAIL b2b_fwd_valid[%0d]: got %b expected %b", n, bus.OutFwdValid, cm); end
      if (cm) begin
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_queue_empty[%0d]: got empty expected entry", n);
        end else begin
          e = exp_q.pop_front();
          checks++; if (bus.OutFwdData !== e) begin failures++; $display("FAIL b2b_fwd_data[%0d]: got %h expected %h", n, bus.OutFwdData, e); end
          checks++; if (bus.OutFwdDest !== d) begin failures++; $display("FAIL b2b_fwd_dest[%0d]: got %h expected %h", n, bus.OutFwdDest, d); end
        end
      end
    end
    checks++; if (bus.OutRetired !== exp_ret) begin failures++; $display("FAIL b2b_retired: got %h expected %h", bus.OutRetired, exp_ret); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.InCtrl = 16'h0000;
    bus.InWord = 16'h0000;
    bus.InByte = 8'h00;
    bus.RdAddrA = 4'd0;
    bus.RdAddrB = 4'd0;
    exp_ret = 16'h0000;
    step();
    test_reset();
    test_word_write();
    test_byte_modes();
    test_bypass();
    test_reset_collision();
    test_halt();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter S, default 15, data word MSB index; data width is S+1 bits.
REQ-002 Parameter A, default 3, register address MSB index; register file holds 2^(A+1) entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-005 InWord  input  S+1  word result from the MEM/WB pipeline buffer.
REQ-006 InByte  input  8  byte result from the MEM/WB pipeline buffer.
REQ-007 InCtrl  input  S+1  control word from the MEM/WB pipeline buffer.
REQ-008 RdAddrA  input  A+1  read port A address.
REQ-009 RdAddrB  input  A+1  read port B address.
REQ-010 OutRdA  output  S+1  read port A data, combinational.
REQ-011 OutRdB  output  S+1  read port B data, combinational.
REQ-012 OutFwdValid  output  1  registered; high for one cycle after each committed write.
REQ-013 OutFwdDest  output  A+1  registered destination of the last committed write.
REQ-014 OutFwdData  output  S+1  registered data of the last committed write.
REQ-015 OutHalted  output  1  high while the FSM is in HALTED.
REQ-016 OutRetired  output  16  count of committed writes, saturating.

Function
REQ-017 Control decode: InCtrl[15]=RegWrite, InCtrl[14:13]=WbSel, InCtrl[12]=Halt, InCtrl[A+8:8]=Dest; all other bits are ignored.
REQ-018 WbSel 00: write data = InWord.
REQ-019 WbSel 01: write data = InByte zero-extended to S+1 bits.
REQ-020 WbSel 10: write data = InByte sign-extended from InByte[7].
REQ-021 WbSel 11: write data = {InByte, RF[Dest][7:0]}, where RF[Dest] is the stored value before the edge (byte-insert read-modify-write).
REQ-022 Commit: in state RUN with RegWrite=1 and Dest!=0, RF[Dest] takes the write data on the rising edge, so the write-to-commit latency is one cycle.
REQ-023 Register 0 reads as 0; writes with Dest=0 are discarded, do not assert OutFwdValid and do not count as retired.
REQ-024 Read ports: OutRdX = 0 when RdAddrX=0.
REQ-025 Read ports: OutRdX = the current write data when a commit is pending this cycle and RdAddrX=Dest (write-through bypass).
REQ-026 Read ports: otherwise OutRdX = RF[RdAddrX].
REQ-027 On each commit, OutFwdValid, OutFwdDest and OutFwdData update at the edge; OutFwdValid returns to 0 on the next edge with no commit, and OutFwdDest/OutFwdData hold their values.
REQ-028 OutRetired increments by 1 per commit and saturates at 16'hFFFF (no wrap).
REQ-029 FSM states RUN and HALTED.
REQ-030 RUN -> HALTED on an edge where InCtrl[12]=1; a RegWrite in the same word still commits on that edge.
REQ-031 HALTED is left only by reset; in HALTED all commits are suppressed, RF and OutRetired are frozen, and read ports stay functional without bypass.
REQ-032 An all-zero InCtrl is a bubble: no state change other than OutFwdValid going to 0.

Reset
REQ-033 With rst=0 at a rising edge: every RF entry = 0, OutRetired = 0, FSM = RUN, OutFwdValid = 0, OutFwdDest = 0, OutFwdData = 0; OutHalted = 0 follows from FSM = RUN.
REQ-034 Reset has priority over any commit or Halt presented in the same cycle; reset in HALTED returns to RUN.
REQ-035 Between reset edges, outputs are defined only by REQ-017 to REQ-032; there is no asynchronous path from rst.

Verification
REQ-036 Word write: InCtrl=16'h8300, InWord=16'hBEEF -> next cycle RF[3]=16'hBEEF, OutFwdValid=1, OutFwdDest=3, OutFwdData=16'hBEEF, OutRetired=1.
REQ-037 Byte modes, with InByte=8'h9A to Dest 5: WbSel=01 -> 16'h009A; WbSel=10 -> 16'hFF9A; with RF[5]=16'h1234, WbSel=11 -> 16'h9A34.
REQ-038 Bypass: commit 16'h5555 to R7 with RdAddrA=7 in the same cycle -> OutRdA=16'h5555 before the edge; RdAddrB=0 -> OutRdB=0; a write to R0 leaves OutRetired unchanged.
REQ-039 Halt: InCtrl=16'h9200, InWord=16'h0001 -> R2=1, OutHalted=1; later InCtrl=16'h8400 -> R4 unchanged, OutRetired frozen; rst=0 -> OutHalted=0 and all registers 0.
REQ-040 Saturation: preload 16'hFFFE retired commits, then 3 further commits -> OutRetired=16'hFFFF, not 16'h0001.
REQ-041 Reset collision: rst=0 in the same cycle as InCtrl=16'h8600 -> R6=0, OutFwdValid=0, OutRetired=0.
